// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronizes and deglitches the bus pins,
// decodes 11-bit frames and queues good bytes in a first-word-fall-through FIFO.
module ps2_rx_fifo #(
    parameter int DEPTH   = 8,
    parameter int FILT    = 8,
    parameter int TIMEOUT = 20000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ps2_clk,
    input  logic                   ps2_data,
    input  logic                   pop,
    input  logic                   clr_err,
    output logic [7:0]             rd_data,
    output logic                   rd_valid,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   parity_err,
    output logic                   frame_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FILT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    // Frame is good when data plus parity hold an odd number of ones.
    function automatic logic f_odd_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    logic [1:0]    r_clk_sync;
    logic [1:0]    r_data_sync;
    logic          r_filt;
    logic          r_filt_d;
    logic [FW-1:0] r_filt_cnt;
    logic          w_fall;
    logic          w_bit;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_par;
    logic [TW-1:0] r_to_cnt;
    logic          r_push;
    logic          w_timeout;
    logic          w_par_ok;
    logic          w_shift_en;
    logic          w_par_en;
    logic          w_push_set;
    logic          w_perr_set;
    logic          w_ferr_set;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic          r_valid;
    logic          r_full;
    logic          r_ovf;
    logic          r_perr;
    logic          r_ferr;
    logic          w_do_push;
    logic          w_do_pop;
    logic          w_ovf_set;

    // Two-flop synchronizers; the idle bus level is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], ps2_clk};
            r_data_sync <= {r_data_sync[0], ps2_data};
        end
    end

    // Clock deglitch: level flips only after FILT consecutive differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_filt     <= 1'b1;
            r_filt_d   <= 1'b1;
            r_filt_cnt <= '0;
        end else begin
            r_filt_d <= r_filt;
            if (r_clk_sync[1] == r_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FW'(FILT - 1)) begin
                r_filt     <= r_clk_sync[1];
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + FW'(1);
            end
        end
    end

    assign w_fall    = r_filt_d & ~r_filt;
    assign w_bit     = r_data_sync[1];
    assign w_par_ok  = f_odd_ok(r_shift, r_par);
    assign w_timeout = (r_state != S_IDLE) && !w_fall && (r_to_cnt == TW'(TIMEOUT - 1));

    // Receiver next-state and event decode.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_en  = 1'b0;
        w_par_en    = 1'b0;
        w_push_set  = 1'b0;
        w_perr_set  = 1'b0;
        w_ferr_set  = 1'b0;
        if (w_timeout) begin
            w_state_nxt = S_IDLE;
            w_ferr_set  = 1'b1;
        end else if (w_fall) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_bit) begin
                        w_state_nxt = S_DATA;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_DATA: begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = S_PARITY;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end
                S_PARITY: begin
                    w_par_en    = 1'b1;
                    w_state_nxt = S_STOP;
                end
                S_STOP: begin
                    w_state_nxt = S_IDLE;
                    w_push_set  = w_par_ok & w_bit;
                    w_perr_set  = ~w_par_ok;
                    w_ferr_set  = ~w_bit;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Receiver state, shift register and inactivity timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_par     <= 1'b0;
            r_to_cnt  <= '0;
            r_push    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_push  <= w_push_set;
            if (w_shift_en) begin
                r_shift   <= {w_bit, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end else if (w_state_nxt == S_IDLE) begin
                r_bit_cnt <= 3'd0;
            end
            if (w_par_en) begin
                r_par <= w_bit;
            end
            if ((r_state == S_IDLE) || w_fall || w_timeout) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + TW'(1);
            end
        end
    end

    assign w_do_pop  = pop & (r_count != CW'(0));
    assign w_do_push = r_push & (~r_full | w_do_pop);
    assign w_ovf_set = r_push & r_full & ~w_do_pop;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // FIFO pointers, occupancy and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_full   <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != CW'(0));
            r_full  <= (w_count_nxt == CW'(DEPTH));
        end
    end

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    // Sticky error flags; a same-cycle set beats clr_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf  <= 1'b0;
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            r_ovf  <= w_ovf_set  | (r_ovf  & ~clr_err);
            r_perr <= w_perr_set | (r_perr & ~clr_err);
            r_ferr <= w_ferr_set | (r_ferr & ~clr_err);
        end
    end

    assign rd_data    = r_mem[r_rd_ptr];
    assign rd_valid   = r_valid;
    assign full       = r_full;
    assign count      = r_count;
    assign overflow   = r_ovf;
    assign parity_err = r_perr;
    assign frame_err  = r_ferr;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: drives PS/2 frames bit by bit and checks
// FIFO contents, occupancy and sticky flags against hand-computed values.
module tb_ps2_rx_fifo;
    localparam int DEPTH   = 8;
    localparam int FILT    = 8;
    localparam int TIMEOUT = 1000;
    localparam int HALF    = 20;
    // Cycles from driving a ps2_clk fall until the push cycle: 2 sync + FILT + edge.
    localparam int PUSH_AT = 2 + FILT + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       pop;
    logic       clr_err;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic [3:0] count;
    logic       overflow;
    logic       parity_err;
    logic       frame_err;

    int total = 0;
    int bad   = 0;

    ps2_rx_fifo #(.DEPTH(DEPTH), .FILT(FILT), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .pop        (pop),
        .clr_err    (clr_err),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .full       (full),
        .count      (count),
        .overflow   (overflow),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic good_par(input logic [7:0] d);
        return ~^d;
    endfunction

    task automatic send_bit(input logic b, input int pop_at);
        ps2_data = b;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        for (int k = 1; k <= HALF; k++) begin
            @(negedge clk);
            if (pop_at > 0) pop = (k == pop_at);
        end
        pop = 1'b0;
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                              input int pop_at);
        send_bit(1'b0, 0);
        for (int i = 0; i < 8; i++) send_bit(d[i], 0);
        send_bit(par, 0);
        send_bit(stp, pop_at);
        ps2_data = 1'b1;
        wait_cyc(HALF);
    endtask

    task automatic pop_one();
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
    endtask

    task automatic clear_errs();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] b;
        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; pop = 1'b0; clr_err = 1'b0;
        wait_cyc(5);
        check("rst_valid", rd_valid, 0);
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_flags", {overflow, parity_err, frame_err}, 0);
        rst = 1'b0;
        wait_cyc(5);

        // Pop while empty is ignored.
        pop_one();
        wait_cyc(2);
        check("empty_pop_count", count, 0);
        check("empty_pop_valid", rd_valid, 0);

        // Good 0x1C frame, then pop.
        send_frame(8'h1C, 1'b0, 1'b1, 0);
        check("a_valid", rd_valid, 1);
        check("a_data", rd_data, 8'h1C);
        check("a_count", count, 1);
        check("a_flags", {overflow, parity_err, frame_err}, 0);
        pop_one();
        wait_cyc(1);
        check("a_pop_valid", rd_valid, 0);
        check("a_pop_count", count, 0);

        // Bad parity.
        send_frame(8'h1C, 1'b1, 1'b1, 0);
        check("p_count", count, 0);
        check("p_perr", parity_err, 1);
        check("p_ferr", frame_err, 0);
        clear_errs();
        check("p_clr", parity_err, 0);

        // Stop bit of 0.
        send_frame(8'h1C, 1'b0, 1'b0, 0);
        check("s_count", count, 0);
        check("s_ferr", frame_err, 1);
        check("s_perr", parity_err, 0);
        clear_errs();
        check("s_clr", frame_err, 0);

        // DEPTH+1 frames with no pop.
        for (int j = 1; j <= DEPTH + 1; j++) begin
            b = 8'(j);
            send_frame(b, good_par(b), 1'b1, 0);
        end
        check("o_full", full, 1);
        check("o_count", count, DEPTH);
        check("o_ovf", overflow, 1);
        for (int j = 1; j <= DEPTH; j++) begin
            check($sformatf("o_pop%0d", j), rd_data, j);
            pop_one();
        end
        wait_cyc(1);
        check("o_drained", count, 0);
        check("o_drained_valid", rd_valid, 0);
        clear_errs();
        check("o_clr", overflow, 0);

        // Full FIFO, push coinciding with a pop.
        for (int j = 1; j <= DEPTH; j++) begin
            b = 8'h10 + 8'(j);
            send_frame(b, good_par(b), 1'b1, 0);
        end
        check("f_full_before", full, 1);
        send_frame(8'hA5, good_par(8'hA5), 1'b1, PUSH_AT);
        check("f_count", count, DEPTH);
        check("f_full", full, 1);
        check("f_ovf", overflow, 0);
        for (int j = 2; j <= DEPTH; j++) begin
            check($sformatf("f_pop%0d", j), rd_data, 8'h10 + j);
            pop_one();
        end
        check("f_newest", rd_data, 8'hA5);
        pop_one();
        wait_cyc(1);
        check("f_empty", count, 0);

        // Timeout on a partial frame.
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        ps2_data = 1'b1;
        wait_cyc(TIMEOUT / 2);
        check("t_not_yet", frame_err, 0);
        wait_cyc(TIMEOUT / 2 + 100);
        check("t_ferr", frame_err, 1);
        check("t_count", count, 0);
        send_frame(8'hF0, 1'b1, 1'b1, 0);
        check("t_data", rd_data, 8'hF0);
        check("t_next_count", count, 1);
        check("t_perr", parity_err, 0);
        pop_one();
        clear_errs();

        // Reset mid-frame with two entries stored and an error flag set.
        send_frame(8'h33, 1'b1, 1'b1, 0);
        send_frame(8'h44, 1'b1, 1'b1, 0);
        send_frame(8'h1C, 1'b1, 1'b1, 0);
        check("r_pre_count", count, 2);
        check("r_pre_perr", parity_err, 1);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        rst = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(3);
        check("r_count", count, 0);
        check("r_valid", rd_valid, 0);
        check("r_flags", {overflow, parity_err, frame_err, full}, 0);
        send_frame(8'h5A, 1'b1, 1'b1, 0);
        check("r_data", rd_data, 8'h5A);
        check("r_next_count", count, 1);
        check("r_next_flags", {overflow, parity_err, frame_err}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8: FIFO entries; must be a power of two, at least 2.
REQ-002 SHALL have parameter FILT, default 8: consecutive equal clk samples needed before the filtered ps2_clk level changes.
REQ-003 SHALL have parameter TIMEOUT, default 20000: clk cycles without a filtered falling edge before a partial frame is discarded.
REQ-004 SHALL have port clk, input, 1 bit: single system clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port ps2_clk, input, 1 bit: raw PS/2 clock pin, asynchronous to clk.
REQ-007 SHALL have port ps2_data, input, 1 bit: raw PS/2 data pin, asynchronous to clk.
REQ-008 SHALL have port pop, input, 1 bit: consumer dequeue request, one entry per cycle it is high.
REQ-009 SHALL have port clr_err, input, 1 bit: clears the sticky error flags.
REQ-010 SHALL have port rd_data, output, 8 bits: head entry, first-word-fall-through; value undefined-but-stable when empty.
REQ-011 SHALL have port rd_valid, output, 1 bit: FIFO is not empty.
REQ-012 SHALL have port full, output, 1 bit: count equals DEPTH.
REQ-013 SHALL have port count, output, clog2(DEPTH)+1 bits: number of stored entries.
REQ-014 SHALL have port overflow, output, 1 bit: sticky; a valid frame was dropped because the FIFO was full.
REQ-015 SHALL have port parity_err, output, 1 bit: sticky; a frame failed the odd-parity check.
REQ-016 SHALL have port frame_err, output, 1 bit: sticky; a frame had a stop bit of 0, or timed out.

Function
REQ-017 SHALL pass ps2_clk and ps2_data each through a 2-flop synchronizer.
REQ-018 SHALL change the filtered clock level only after FILT consecutive synchronized samples differ from the current level; the filtered level resets to 1.
REQ-019 SHALL define a falling edge as the filtered clock going 1->0 and SHALL sample synchronized ps2_data on that edge only.
REQ-020 SHALL implement receiver FSM states IDLE, DATA, PARITY, STOP.
REQ-021 SHALL, in IDLE, go to DATA on an edge that samples 0 (start bit), and SHALL stay in IDLE with no flag change on an edge that samples 1.
REQ-022 SHALL, in DATA, shift in 8 bits LSB first using a 3-bit counter, and go to PARITY after the 8th bit.
REQ-023 SHALL, in PARITY, capture the bit and go to STOP; the frame is good when the data bits plus the parity bit contain an odd number of ones.
REQ-024 SHALL, in STOP, always return to IDLE, handling the sampled stop bit as follows.
REQ-025 SHALL, on a STOP sample, push the byte if parity is good and the stop bit is 1.
REQ-026 SHALL, on a STOP sample, set parity_err on bad parity, set frame_err on stop=0, and not push in either case.
REQ-027 SHALL, in any state other than IDLE, count clk cycles since the last falling edge; on reaching TIMEOUT it SHALL set frame_err, discard the partial frame and return to IDLE.
REQ-028 SHALL perform a push in the cycle after the stop-bit edge; rd_valid and count SHALL reflect the push in the following cycle.
REQ-029 SHALL use clog2(DEPTH)-bit read and write pointers that wrap modulo DEPTH.
REQ-030 SHALL ignore pop when the FIFO is empty: no pointer or count change.
REQ-031 SHALL drop a push when full and there is no pop in the same cycle, and set overflow.
REQ-032 SHALL, on push and pop in the same cycle, perform both (including when full or when count is 1), leaving count unchanged.
REQ-033 SHALL clear all three sticky flags on clr_err; if a flag-setting event occurs in the same cycle, the set SHALL win.

Reset
REQ-034 SHALL, while rst is high, force FSM=IDLE, pointers=0, count=0, rd_valid=0, full=0, overflow=0, parity_err=0, frame_err=0, synchronizers and filtered clock to 1, and bit and timeout counters to 0.
REQ-035 SHALL discard a frame in progress when rst is asserted; after release, reception SHALL resume at the next start bit.
REQ-036 SHALL keep storage RAM contents unchanged by rst.

Verification
REQ-037 Bench SHALL cover: frame 0x1C with parity 0 and stop 1 -> rd_valid=1, rd_data=0x1C, count=1; then pop -> rd_valid=0, count=0.
REQ-038 Bench SHALL cover: 0x1C with parity 1 -> no push, parity_err=1; then clr_err -> parity_err=0.
REQ-039 Bench SHALL cover: DEPTH+1 frames (0x01 to 0x09, DEPTH=8) with no pop -> full=1, count=8, overflow=1; pops return 0x01 to 0x08 in order.
REQ-040 Bench SHALL cover: FIFO full, new frame pushed in the same cycle as a pop -> count stays 8, overflow=0, newest byte stored.
REQ-041 Bench SHALL cover: start bit plus 4 data bits, then ps2_clk held high for TIMEOUT cycles -> frame_err=1, FSM IDLE; next 0xF0 frame with parity 1 is pushed correctly.
REQ-042 Bench SHALL cover: rst pulsed mid-frame with 2 entries stored -> count=0 and all flags 0; next full 0x5A frame with parity 1 -> rd_data=0x5A.
